// File: rtl/hex_seq_pkg.sv
// Shared definitions for the HEX display sequencer: FSM states, register map,
// active-low segment table (gfedcba) and the blank code.
package hex_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] REG_VALUE  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_MASK   = 2'd3;

  // Index 0 is the last element of the concatenation (digit '0' = 7'h40).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // All segments off in active-low polarity.
  localparam logic [6:0] BLANK_CODE = 7'h7F;

endpackage

// File: rtl/hex_seg_encoder.sv
// Nibble to 7-segment code (bit0=a .. bit6=g), with blanking.
// Purely combinational; the table is active-low and is inverted when
// ACTIVE_LOW=0 (the blank code inverts to 7'h00 along with it).
module hex_seg_encoder
  import hex_seq_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] code
);

  logic [6:0] code_al;

  // Select the active-low pattern, then apply the board polarity.
  always_comb begin
    code_al = blank ? BLANK_CODE : SEG_TABLE[nibble];
    code    = (ACTIVE_LOW != 0) ? code_al : ~code_al;
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// CPU-facing register block that sweeps a 32-bit value onto per-digit HEX PIOs.
// Sweep starts two cycles after the triggering CPU write, one master write per digit.
// Master outputs hold while m_waitrequest is high; CPU writes mid-sweep coalesce into one follow-up sweep.
module hex_display_sequencer
  import hex_seq_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ADDR_W       = 8,
  parameter int BASE_ADDR    = 0,
  parameter int DIGIT_STRIDE = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        s_address,
  input  logic              s_chipselect,
  input  logic              s_write_n,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [6:0]        m_writedata,
  input  logic              m_waitrequest
);

  state_t      state, next_state;
  logic [31:0] value_reg, shadow_value;
  logic [7:0]  mask_reg, shadow_mask;
  logic        enable, blank_lz, shadow_blz, pending;
  logic [2:0]  idx;
  logic        reg_wr, pend_set, load, advance, last_digit, busy;
  logic [7:0]  lz_blank;
  logic        all_zero;
  logic [31:0] addr_full;
  logic [6:0]  seg_code;

  assign reg_wr     = s_chipselect && !s_write_n;
  assign busy       = (state != ST_IDLE);
  assign last_digit = (idx == 3'(NUM_DIGITS - 1));

  // Anything that may change what the display should show requests a sweep.
  always_comb begin
    pend_set = 1'b0;
    if (reg_wr) begin
      case (s_address)
        REG_VALUE: pend_set = 1'b1;
        REG_MASK:  pend_set = 1'b1;
        REG_CTRL:  pend_set = s_writedata[0] || s_writedata[2];
        default:   pend_set = 1'b0;
      endcase
    end
  end

  // CPU-visible registers; force is a strobe and is never stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= '0;
      mask_reg  <= '0;
      enable    <= 1'b0;
      blank_lz  <= 1'b0;
    end else if (reg_wr) begin
      case (s_address)
        REG_VALUE: value_reg <= s_writedata;
        REG_CTRL: begin
          enable   <= s_writedata[0];
          blank_lz <= s_writedata[1];
        end
        REG_MASK:  mask_reg <= s_writedata[7:0];
        default:   ;
      endcase
    end
  end

  // Pending: a new request wins over the clear taken when a sweep loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pending <= 1'b0;
    else if (pend_set) pending <= 1'b1;
    else if (load)     pending <= 1'b0;
  end

  // Read mux, decoded from the address alone.
  always_comb begin
    s_readdata = '0;
    case (s_address)
      REG_VALUE:  s_readdata = value_reg;
      REG_CTRL:   s_readdata = {30'd0, blank_lz, enable};
      REG_STATUS: s_readdata = {30'd0, pending, busy};
      REG_MASK:   s_readdata = {24'd0, mask_reg};
      default:    s_readdata = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic: idle -> one load cycle -> back-to-back digit writes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE:  if (pending && enable) next_state = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          if (last_digit) next_state = ST_IDLE;
          else            advance    = 1'b1;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Snapshot and digit index: the sweep only ever sees the shadow copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_value <= '0;
      shadow_mask  <= '0;
      shadow_blz   <= 1'b0;
      idx          <= '0;
    end else if (load) begin
      shadow_value <= value_reg;
      shadow_mask  <= mask_reg;
      shadow_blz   <= blank_lz;
      idx          <= '0;
    end else if (advance) begin
      idx <= idx + 3'd1;
    end
  end

  // Leading-zero blanking: scan from the top digit down; digit 0 is exempt.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i < NUM_DIGITS) begin
        all_zero = all_zero && (shadow_value[i*4 +: 4] == 4'h0);
        if (i > 0) lz_blank[i] = shadow_blz && all_zero;
      end
    end
  end

  hex_seg_encoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
    .nibble (shadow_value[{idx, 2'b00} +: 4]),
    .blank  (shadow_mask[idx] || lz_blank[idx]),
    .code   (seg_code)
  );

  // Master outputs are decoded from state/idx/shadow, so they stay put under stall.
  always_comb begin
    addr_full   = 32'(BASE_ADDR) + 32'(idx) * 32'(DIGIT_STRIDE);
    m_write     = (state == ST_WRITE);
    m_address   = m_write ? addr_full[ADDR_W-1:0] : '0;
    m_writedata = m_write ? seg_code : 7'd0;
  end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Scoreboard bench for hex_display_sequencer: expected digit writes are queued
// when the CPU stimulus is issued and popped as the master port accepts writes.
module tb_hex_display_sequencer;

  logic        clk, reset_n;
  logic [1:0]  s_address;
  logic        s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic [7:0]  m_address;
  logic        m_write, m_waitrequest;
  logic [6:0]  m_writedata;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int stall_win_cycles = 0;
  int stall_left = 0;
  logic [14:0] sb[$];
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_sequencer dut (
    .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_chipselect(s_chipselect),
    .s_write_n(s_write_n), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave stall generator: stalls the digit-1 write for stall_left cycles.
  initial begin
    m_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && m_write === 1'b1 && m_address === 8'h10) begin
        m_waitrequest = 1'b1;
        stall_left--;
      end else begin
        m_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: hold-stability under stall, and scoreboard compare on acceptance.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_addr;
    logic [6:0] prev_data;
    logic [14:0] exp;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_write !== 1'b1 || m_address !== prev_addr || m_writedata !== prev_data) begin
            errors++;
            $display("FAIL hold_stable: got wr=%b addr=%h data=%h, need wr=1 addr=%h data=%h",
                     m_write, m_address, m_writedata, prev_addr, prev_data);
          end
        end
        if (m_write === 1'b1 && m_address === 8'h10) stall_win_cycles++;
        if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h with nothing expected", m_address, m_writedata);
          end else begin
            exp = sb.pop_front();
            if ({m_address, m_writedata} !== exp) begin
              errors++;
              $display("FAIL digit_write: got addr=%h data=%h, need addr=%h data=%h",
                       m_address, m_writedata, exp[14:7], exp[6:0]);
            end
          end
          accepted++;
        end
        prev_stall = (m_write === 1'b1) && (m_waitrequest === 1'b1);
        prev_addr  = m_address;
        prev_data  = m_writedata;
      end
    end
  end

  // Reference model of one sweep for NUM_DIGITS=4, stride 16, active-low.
  task automatic push_sweep(input logic [31:0] v, input logic [7:0] m, input logic blz);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blank;
    for (int i = 0; i < 4; i++) begin
      nib   = v[i*4 +: 4];
      upper = v[15:0] >> (4 * i);
      blank = m[i] || (blz && i > 0 && upper == 16'h0);
      sb.push_back({8'(i * 16), blank ? 7'h7F : seg_tab[nib]});
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_chipselect = 1'b1; s_write_n = 1'b0; s_address = a; s_writedata = d;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, d, exp);
    end
  endtask

  task automatic wait_drained(input string name);
    logic [31:0] st;
    bit done;
    done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      cpu_read(2'd2, st);
      if (sb.size() == 0 && st[0] == 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: %0d writes still outstanding, need 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    checks++;
    if (m_write !== 1'b0 || m_address !== 8'h00 || m_writedata !== 7'h00) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b addr=%h data=%h, need 0 0 0", m_write, m_address, m_writedata);
    end
    check_reg("reset_value", 2'd0, 32'h0);
    check_reg("reset_ctrl", 2'd1, 32'h0);
    check_reg("reset_status", 2'd2, 32'h0);
    check_reg("reset_mask", 2'd3, 32'h0);
  endtask

  task automatic test_basic;
    int base;
    base = accepted;
    push_sweep(32'h1234, 8'h0, 1'b0);
    cpu_write(2'd0, 32'h1234);
    cpu_write(2'd1, 32'h1);
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0) begin errors++; $display("FAIL latency_idle: got wr=%b, need 0", m_write); end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b0) begin errors++; $display("FAIL latency_load: got wr=%b, need 0", m_write); end
    @(negedge clk);
    checks++;
    if (m_write !== 1'b1 || m_address !== 8'h00) begin
      errors++; $display("FAIL latency_first: got wr=%b addr=%h, need wr=1 addr=00", m_write, m_address);
    end
    wait_drained("basic");
    check_reg("basic_status", 2'd2, 32'h0);
    checks++;
    if (accepted - base !== 4) begin errors++; $display("FAIL basic_count: got %0d, need 4", accepted - base); end
  endtask

  task automatic test_waitrequest;
    int base;
    base = accepted;
    stall_win_cycles = 0;
    stall_left = 3;
    push_sweep(32'hABCD, 8'h0, 1'b0);
    cpu_write(2'd0, 32'hABCD);
    wait_drained("stall");
    checks++;
    if (stall_win_cycles !== 4) begin
      errors++; $display("FAIL stall_hold_cycles: got %0d, need 4", stall_win_cycles);
    end
    checks++;
    if (accepted - base !== 4) begin errors++; $display("FAIL stall_count: got %0d, need 4", accepted - base); end
  endtask

  task automatic test_blanking;
    cpu_write(2'd1, 32'h0);
    cpu_write(2'd0, 32'h0005);
    push_sweep(32'h0005, 8'h0, 1'b1);
    cpu_write(2'd1, 32'h3);
    wait_drained("blank_lz");
    cpu_write(2'd1, 32'h0);
    cpu_write(2'd3, 32'h1);
    push_sweep(32'h0005, 8'h1, 1'b0);
    cpu_write(2'd1, 32'h1);
    wait_drained("mask");
  endtask

  task automatic test_back_to_back;
    int base;
    bit seen;
    push_sweep(32'h0005, 8'h0, 1'b0);
    cpu_write(2'd3, 32'h0);
    wait_drained("mask_clear");
    base = accepted;
    push_sweep(32'h1234, 8'h0, 1'b0);
    cpu_write(2'd0, 32'h1234);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (m_write === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL coalesce_start: got no write, need sweep"); end
    cpu_write(2'd0, 32'h1111);
    check_reg("coalesce_status", 2'd2, 32'h3);
    cpu_write(2'd0, 32'h2222);
    cpu_write(2'd0, 32'h3333);
    push_sweep(32'h3333, 8'h0, 1'b0);
    wait_drained("coalesce");
    checks++;
    if (accepted - base !== 8) begin errors++; $display("FAIL coalesce_count: got %0d, need 8", accepted - base); end
  endtask

  task automatic test_enable;
    int base;
    cpu_write(2'd1, 32'h0);
    base = accepted;
    cpu_write(2'd0, 32'h00F0);
    repeat (20) @(negedge clk);
    checks++;
    if (accepted !== base) begin errors++; $display("FAIL disabled_quiet: got %0d writes, need 0", accepted - base); end
    check_reg("disabled_status", 2'd2, 32'h2);
    push_sweep(32'h00F0, 8'h0, 1'b0);
    cpu_write(2'd1, 32'h1);
    wait_drained("reenable");
    push_sweep(32'h00F0, 8'h0, 1'b0);
    cpu_write(2'd1, 32'h5);
    wait_drained("force");
    check_reg("force_ctrl", 2'd1, 32'h1);
    checks++;
    if (accepted - base !== 8) begin errors++; $display("FAIL enable_count: got %0d, need 8", accepted - base); end
  endtask

  task automatic test_reset_mid;
    int base;
    bit seen;
    push_sweep(32'h4321, 8'h0, 1'b0);
    cpu_write(2'd0, 32'h4321);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (m_write === 1'b1 && m_address === 8'h20) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid_reach: got no digit 2 write, need one"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (m_write !== 1'b0 || m_address !== 8'h00 || m_writedata !== 7'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got wr=%b addr=%h data=%h, need 0 0 0", m_write, m_address, m_writedata);
    end
    sb.delete();
    check_reg("reset_mid_value", 2'd0, 32'h0);
    check_reg("reset_mid_ctrl", 2'd1, 32'h0);
    check_reg("reset_mid_status", 2'd2, 32'h0);
    check_reg("reset_mid_mask", 2'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    base = accepted;
    repeat (20) @(negedge clk);
    checks++;
    if (accepted !== base) begin errors++; $display("FAIL post_reset_quiet: got %0d writes, need 0", accepted - base); end
  endtask

  initial begin
    reset_n = 1'b0; s_address = 2'd0; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    test_basic;
    test_waitrequest;
    test_blanking;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
